// File: rtl/axi4_stream_pkg.sv
// Shared definitions for the AXI4-Stream round-robin arbiter.
//   calc_data_w / calc_keep_w : round a requested bus width up to whole bytes
//   calc_idx_w                : width of a source index
//   arb_state_t               : arbiter FSM encoding
package axi4_stream_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    function automatic int unsigned calc_data_w(input int unsigned bus_width);
        return (((bus_width - 1) / 8) + 1) * 8;
    endfunction

    function automatic int unsigned calc_keep_w(input int unsigned bus_width);
        return calc_data_w(bus_width) / 8;
    endfunction

    function automatic int unsigned calc_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_sel.sv
// Combinational round-robin selector: picks the first asserted request
// searching upward from (last_grant+1) mod N_SRC with wrap-around.
//   req        : per-source request vector
//   last_grant : index of the previously served source
//   grant      : one-hot winner (all zero when no request)
//   index      : binary winner index (zero when no request)
module rr_priority_sel
    import axi4_stream_pkg::*;
#(
    parameter  int unsigned N_SRC = 4,
    localparam int unsigned IDX_W = calc_idx_w(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_SRC-1:0] grant,
    output logic [IDX_W-1:0] index
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Walk the ring once, starting just after the last winner.
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= N_SRC; k++) begin
            cand = IDX_W'((32'(last_grant) + k) % N_SRC);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end

endmodule

// File: rtl/axi4_stream_rr_arbiter.sv
// Packet-level round-robin arbiter merging N_SRC AXI4-Stream sources onto one
// master port. A source keeps the grant until its tlast beat is accepted;
// each packet costs one arbitration bubble. Output is a single register stage.
//   aclk, aresetn                       : clock, async active-low reset
//   s_tvalid/s_tready/s_tdata/s_tkeep/s_tlast : packed slave ports
//   m_tvalid/m_tready/m_tdata/m_tkeep/m_tlast : master port
//   grant_id : index of the granted (or last granted) source
//   busy     : high while a packet is locked
module axi4_stream_rr_arbiter
    import axi4_stream_pkg::*;
#(
    parameter  int unsigned N_SRC     = 4,
    parameter  int unsigned BUS_WIDTH = 32,
    localparam int unsigned DATA_W    = calc_data_w(BUS_WIDTH),
    localparam int unsigned KEEP_W    = calc_keep_w(BUS_WIDTH),
    localparam int unsigned IDX_W     = calc_idx_w(N_SRC)
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [N_SRC-1:0]        s_tvalid,
    output logic [N_SRC-1:0]        s_tready,
    input  logic [N_SRC*DATA_W-1:0] s_tdata,
    input  logic [N_SRC*KEEP_W-1:0] s_tkeep,
    input  logic [N_SRC-1:0]        s_tlast,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [DATA_W-1:0]       m_tdata,
    output logic [KEEP_W-1:0]       m_tkeep,
    output logic                    m_tlast,
    output logic [IDX_W-1:0]        grant_id,
    output logic                    busy
);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [IDX_W-1:0] last_grant;
    logic [N_SRC-1:0] grant_q;
    logic [N_SRC-1:0] sel_grant;
    logic [IDX_W-1:0] sel_index;

    logic              out_ready_c;
    logic              arb_c;
    logic              accept_c;
    logic              pkt_end_c;
    logic              src_valid_c;
    logic              src_last_c;
    logic [DATA_W-1:0] src_data_c;
    logic [KEEP_W-1:0] src_keep_c;

    rr_priority_sel #(
        .N_SRC (N_SRC)
    ) u_sel (
        .req        (s_tvalid),
        .last_grant (last_grant),
        .grant      (sel_grant),
        .index      (sel_index)
    );

    // One-hot mux of the granted source's payload.
    always_comb begin
        src_valid_c = 1'b0;
        src_last_c  = 1'b0;
        src_data_c  = '0;
        src_keep_c  = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (grant_q[i]) begin
                src_valid_c = s_tvalid[i];
                src_last_c  = s_tlast[i];
                src_data_c  = s_tdata[i*DATA_W +: DATA_W];
                src_keep_c  = s_tkeep[i*KEEP_W +: KEEP_W];
            end
        end
    end

    // The output register can take a beat when empty or draining this cycle.
    assign out_ready_c = !m_tvalid || m_tready;
    assign arb_c       = (state == ARB_IDLE) && (|s_tvalid);
    assign accept_c    = (state == ARB_LOCKED) && src_valid_c && out_ready_c;
    assign pkt_end_c   = accept_c && src_last_c;

    // Next-state and slave-side ready; readies are zero in IDLE (the bubble).
    always_comb begin
        state_nxt = state;
        s_tready  = '0;
        case (state)
            ARB_IDLE: begin
                if (arb_c) begin
                    state_nxt = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                if (out_ready_c) begin
                    s_tready = grant_q;
                end
                if (pkt_end_c) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant bookkeeping; last_grant starts at N_SRC-1 so source 0 wins first.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            grant_q    <= '0;
            grant_id   <= '0;
            last_grant <= IDX_W'(N_SRC - 1);
            busy       <= 1'b0;
        end else begin
            busy <= (state_nxt == ARB_LOCKED);
            if (arb_c) begin
                grant_q  <= sel_grant;
                grant_id <= sel_index;
            end
            if (pkt_end_c) begin
                last_grant <= grant_id;
            end
        end
    end

    // Output register stage; payload only moves on an accepted beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
        end else begin
            if (out_ready_c) begin
                m_tvalid <= accept_c;
            end
            if (accept_c) begin
                m_tdata <= src_data_c;
                m_tkeep <= src_keep_c;
                m_tlast <= src_last_c;
            end
        end
    end

endmodule

// File: tb/tb_axi4_stream_rr_arbiter.sv
// Directed bench for axi4_stream_rr_arbiter (N_SRC=4, 32-bit data).
// Source i drives data {8'h10+i, 16'h0, dat} and fixed keep (F,7,3,1).
module tb_axi4_stream_rr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned KW = 4;
    localparam int unsigned IW = 2;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tready;
    logic [N*DW-1:0] s_tdata;
    logic [N*KW-1:0] s_tkeep;
    logic [N-1:0]    s_tlast;
    logic            m_tvalid;
    logic            m_tready;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tlast;
    logic [IW-1:0]   grant_id;
    logic            busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 aclk = ~aclk;

    axi4_stream_rr_arbiter #(
        .N_SRC     (4),
        .BUS_WIDTH (32)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tlast  (s_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast),
        .grant_id (grant_id),
        .busy     (busy)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic [7:0]  dat;
        logic        mrdy;
        logic [3:0]  srdy;
        logic        mvld;
        logic [31:0] mdata;
        logic [3:0]  mkeep;
        logic        mlast;
        logic [1:0]  gid;
        logic        bsy;
    } vec_t;

    vec_t tbl[27];

    function automatic vec_t mk(input logic rst, input logic [3:0] vld, input logic [3:0] lst,
                                input logic [7:0] dat, input logic mrdy, input logic [3:0] srdy,
                                input logic mvld, input logic [31:0] mdata, input logic [3:0] mkeep,
                                input logic mlast, input logic [1:0] gid, input logic bsy);
        vec_t v;
        v.rst = rst; v.vld = vld; v.lst = lst; v.dat = dat; v.mrdy = mrdy;
        v.srdy = srdy; v.mvld = mvld; v.mdata = mdata; v.mkeep = mkeep;
        v.mlast = mlast; v.gid = gid; v.bsy = bsy;
        return v;
    endfunction

    task automatic drive(input logic [3:0] vld, input logic [3:0] lst,
                         input logic [7:0] dat, input logic mrdy);
        s_tvalid = vld;
        s_tlast  = lst;
        m_tready = mrdy;
        for (int i = 0; i < N; i++) begin
            s_tdata[i*DW +: DW] = {8'(8'h10 + i), 16'h0, dat};
        end
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    initial begin
        aresetn = 1'b0;
        s_tkeep = 16'h137F;
        drive(4'b0000, 4'b0000, 8'h00, 1'b1);

        //        rst vld      lst      dat    mr  srdy     mv mdata         mk    ml gid   bsy
        // 3-beat packet from source 2 straight out of reset
        tbl[0]  = mk(1, 4'b0100, 4'b0000, 8'hA1, 1, 4'b0000, 0, 32'h0,        4'h0, 0, 2'd0, 0);
        tbl[1]  = mk(0, 4'b0100, 4'b0000, 8'hA1, 1, 4'b0000, 0, 32'h0,        4'h0, 0, 2'd0, 0);
        tbl[2]  = mk(0, 4'b0100, 4'b0000, 8'hA1, 1, 4'b0100, 0, 32'h0,        4'h0, 0, 2'd2, 1);
        tbl[3]  = mk(0, 4'b0100, 4'b0000, 8'hA2, 1, 4'b0100, 1, 32'h120000A1, 4'h3, 0, 2'd2, 1);
        tbl[4]  = mk(0, 4'b0100, 4'b0100, 8'hA3, 1, 4'b0100, 1, 32'h120000A2, 4'h3, 0, 2'd2, 1);
        tbl[5]  = mk(0, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 1, 32'h120000A3, 4'h3, 1, 2'd2, 0);
        tbl[6]  = mk(0, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 0, 32'h120000A3, 4'h3, 1, 2'd2, 0);
        // reset, then all four sources stream 1-beat packets: order 0,1,2,3,0
        tbl[7]  = mk(1, 4'b1111, 4'b1111, 8'hB1, 1, 4'b0000, 0, 32'h0,        4'h0, 0, 2'd0, 0);
        tbl[8]  = mk(0, 4'b1111, 4'b1111, 8'hB1, 1, 4'b0000, 0, 32'h0,        4'h0, 0, 2'd0, 0);
        tbl[9]  = mk(0, 4'b1111, 4'b1111, 8'hB1, 1, 4'b0001, 0, 32'h0,        4'h0, 0, 2'd0, 1);
        tbl[10] = mk(0, 4'b1111, 4'b1111, 8'hB1, 1, 4'b0000, 1, 32'h100000B1, 4'hF, 1, 2'd0, 0);
        tbl[11] = mk(0, 4'b1111, 4'b1111, 8'hB1, 1, 4'b0010, 0, 32'h100000B1, 4'hF, 1, 2'd1, 1);
        tbl[12] = mk(0, 4'b1111, 4'b1111, 8'hB1, 1, 4'b0000, 1, 32'h110000B1, 4'h7, 1, 2'd1, 0);
        tbl[13] = mk(0, 4'b1111, 4'b1111, 8'hB1, 1, 4'b0100, 0, 32'h110000B1, 4'h7, 1, 2'd2, 1);
        tbl[14] = mk(0, 4'b1111, 4'b1111, 8'hB1, 1, 4'b0000, 1, 32'h120000B1, 4'h3, 1, 2'd2, 0);
        tbl[15] = mk(0, 4'b1111, 4'b1111, 8'hB1, 1, 4'b1000, 0, 32'h120000B1, 4'h3, 1, 2'd3, 1);
        tbl[16] = mk(0, 4'b1111, 4'b1111, 8'hB1, 1, 4'b0000, 1, 32'h130000B1, 4'h1, 1, 2'd3, 0);
        tbl[17] = mk(0, 4'b1111, 4'b1111, 8'hB1, 1, 4'b0001, 0, 32'h130000B1, 4'h1, 1, 2'd0, 1);
        tbl[18] = mk(0, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 1, 32'h100000B1, 4'hF, 1, 2'd0, 0);
        // source 1 sends 4 beats while source 0 waits, then source 0 is served
        tbl[19] = mk(0, 4'b0011, 4'b0000, 8'hC1, 1, 4'b0000, 0, 32'h100000B1, 4'hF, 1, 2'd0, 0);
        tbl[20] = mk(0, 4'b0011, 4'b0000, 8'hC1, 1, 4'b0010, 0, 32'h100000B1, 4'hF, 1, 2'd1, 1);
        tbl[21] = mk(0, 4'b0011, 4'b0000, 8'hC2, 1, 4'b0010, 1, 32'h110000C1, 4'h7, 0, 2'd1, 1);
        tbl[22] = mk(0, 4'b0011, 4'b0000, 8'hC3, 1, 4'b0010, 1, 32'h110000C2, 4'h7, 0, 2'd1, 1);
        tbl[23] = mk(0, 4'b0011, 4'b0011, 8'hC4, 1, 4'b0010, 1, 32'h110000C3, 4'h7, 0, 2'd1, 1);
        tbl[24] = mk(0, 4'b0001, 4'b0001, 8'hD0, 1, 4'b0000, 1, 32'h110000C4, 4'h7, 1, 2'd1, 0);
        tbl[25] = mk(0, 4'b0001, 4'b0001, 8'hD0, 1, 4'b0001, 0, 32'h110000C4, 4'h7, 1, 2'd0, 1);
        tbl[26] = mk(0, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 1, 32'h100000D0, 4'hF, 1, 2'd0, 0);

        for (int t = 0; t < 27; t++) begin
            @(negedge aclk);
            aresetn = !tbl[t].rst;
            drive(tbl[t].vld, tbl[t].lst, tbl[t].dat, tbl[t].mrdy);
            #1;
            check($sformatf("vec%0d {srdy,mvld,mdata,mkeep,mlast,gid,busy}", t),
                  64'({s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, grant_id, busy}),
                  64'({tbl[t].srdy, tbl[t].mvld, tbl[t].mdata, tbl[t].mkeep,
                       tbl[t].mlast, tbl[t].gid, tbl[t].bsy}));
        end

        // m_tready toggling 1010... while source 2 sends A,B,C,D
        begin : toggle_seq
            int          beat;
            int          got;
            logic        stalled;
            logic [37:0] snap;
            logic [31:0] expd;
            beat    = 0;
            got     = 0;
            stalled = 1'b0;
            snap    = '0;
            for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
                @(negedge aclk);
                drive((beat < 4) ? 4'b0100 : 4'b0000, (beat == 3) ? 4'b0100 : 4'b0000,
                      8'(8'h0A + beat), (cyc % 2) == 0);
                #1;
                if (stalled) begin
                    check("stall_hold", 64'({m_tvalid, m_tdata, m_tkeep, m_tlast}), 64'(snap));
                end
                if (m_tvalid && m_tready) begin
                    expd = {8'h12, 16'h0, 8'(8'h0A + got)};
                    check($sformatf("toggle_beat%0d {data,last}", got),
                          64'({m_tdata, m_tlast}), 64'({expd, got == 3}));
                    got++;
                end
                stalled = m_tvalid && !m_tready;
                snap    = {m_tvalid, m_tdata, m_tkeep, m_tlast};
                if (s_tvalid[2] && s_tready[2]) begin
                    beat++;
                end
            end
            check("toggle_beats_seen", 64'(got), 64'd4);
            @(negedge aclk);
            drive(4'b0000, 4'b0000, 8'h00, 1'b1);
            #1;
            check("toggle_no_dup", 64'(m_tvalid), 64'd0);
        end

        // reset after beat 2 of a 5-beat packet from source 1, then source 3
        @(negedge aclk);
        drive(4'b0010, 4'b0000, 8'h51, 1'b1);
        @(negedge aclk);
        drive(4'b0010, 4'b0000, 8'h51, 1'b1);
        #1;
        check("rst_mid_grant", 64'({grant_id, busy}), 64'({2'd1, 1'b1}));
        @(negedge aclk);
        drive(4'b0010, 4'b0000, 8'h52, 1'b1);
        @(negedge aclk);
        drive(4'b0010, 4'b0000, 8'h53, 1'b1);
        #1;
        check("rst_mid_beat2", 64'({m_tvalid, m_tdata}), 64'({1'b1, 32'h11000052}));
        aresetn = 1'b0;
        #1;
        check("rst_mid_flush {mvld,busy,srdy,gid,mdata,mlast}",
              64'({m_tvalid, busy, s_tready, grant_id, m_tdata, m_tlast}), 64'd0);
        @(negedge aclk);
        drive(4'b1000, 4'b1000, 8'h3E, 1'b1);
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        check("post_rst_idle {busy,srdy}", 64'({busy, s_tready}), 64'd0);
        @(negedge aclk);
        #1;
        check("post_rst_grant {gid,busy,srdy}", 64'({grant_id, busy, s_tready}),
              64'({2'd3, 1'b1, 4'b1000}));
        @(negedge aclk);
        drive(4'b0000, 4'b0000, 8'h00, 1'b1);
        #1;
        check("post_rst_beat {mvld,mdata,mkeep,mlast}",
              64'({m_tvalid, m_tdata, m_tkeep, m_tlast}),
              64'({1'b1, 32'h1300003E, 4'h1, 1'b1}));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi4_stream_rr_arbiter.md
AXI4_STREAM_RR_ARBITER -- requirements
Module: axi4_stream_rr_arbiter

Interface
REQ-001 SHALL have parameter N_SRC, default 4: number of AXI4-Stream sources (2..16).
REQ-002 SHALL have parameter BUS_WIDTH, default 32: requested data width, rounded up to bytes. DATA_W = (((BUS_WIDTH-1)/8)+1)*8 and KEEP_W = DATA_W/8.
REQ-003 SHALL have port aclk, input, 1: the single clock.
REQ-004 SHALL have port aresetn, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port s_tvalid, input, N_SRC: per-source valid.
REQ-006 SHALL have port s_tready, output, N_SRC: per-source ready.
REQ-007 SHALL have port s_tdata, input, N_SRC*DATA_W: packed source data, source i at [i*DATA_W +: DATA_W].
REQ-008 SHALL have port s_tkeep, input, N_SRC*KEEP_W: packed source byte enables.
REQ-009 SHALL have port s_tlast, input, N_SRC: per-source end of packet.
REQ-010 SHALL have port m_tvalid, output, 1: output valid.
REQ-011 SHALL have port m_tready, input, 1: downstream ready.
REQ-012 SHALL have port m_tdata, output, DATA_W: output data.
REQ-013 SHALL have port m_tkeep, output, KEEP_W: output byte enables.
REQ-014 SHALL have port m_tlast, output, 1: output end of packet.
REQ-015 SHALL have port grant_id, output, $clog2(N_SRC): index of the source currently granted.
REQ-016 SHALL have port busy, output, 1: high while a packet is locked.

Function
REQ-017 SHALL implement the FSM states IDLE and LOCKED.
REQ-018 In IDLE with any s_tvalid high, SHALL grant the first requester found searching upward from (last_grant+1) mod N_SRC with wrap-around, then go to LOCKED on the next edge.
REQ-019 In IDLE, s_tready SHALL be all zero; arbitration costs exactly one bubble cycle per packet.
REQ-020 In LOCKED, s_tready[i] SHALL equal grant[i] & (!m_tvalid | m_tready); all non-granted readies SHALL be 0.
REQ-021 Output SHALL be a single register stage: an accepted source beat appears on m_* the next cycle; latency is 1 and sustained throughput is 1 beat/cycle under continuous m_tready.
REQ-022 m_tdata/m_tkeep/m_tlast SHALL hold stable while m_tvalid=1 and m_tready=0.
REQ-023 Acceptance of a beat with s_tlast=1 from the granted source SHALL return the FSM to IDLE and update last_grant to the granted index.
REQ-024 Grant SHALL never change mid-packet, regardless of other requesters.
REQ-025 A granted source that drops s_tvalid mid-packet SHALL stay granted; no timeout.
REQ-026 A single requesting source SHALL be re-granted after each packet, with one bubble between packets.
REQ-027 busy SHALL equal (state==LOCKED); grant_id SHALL hold the last granted index in IDLE.

Reset
REQ-028 On aresetn=0, asynchronously: state=IDLE, last_grant=N_SRC-1 (so source 0 wins first), m_tvalid=0, m_tlast=0, m_tdata=0, m_tkeep=0, grant_id=0, busy=0, s_tready=0.
REQ-029 Reset mid-packet SHALL discard the partial packet with no recovery; the first post-reset beat SHALL start a fresh arbitration.

Structure
REQ-030 A shared package axi4_stream_pkg SHALL hold the DATA_W/KEEP_W rounding functions and the arbiter state enum (ARB_IDLE, ARB_LOCKED).
REQ-031 The round-robin priority search SHALL be a sub-module rr_priority_sel (inputs req and last_grant; outputs grant one-hot and index), combinational.

Verification
REQ-032 Reset release with only s_tvalid[2]=1 and a 3-beat packet -> grant_id=2, beats appear on m_* in cycles 2..4 after the request, m_tlast on the 3rd, busy drops the next cycle.
REQ-033 All four sources continuously request 1-beat packets -> grant order 0,1,2,3,0 with a bubble between each.
REQ-034 Source 1 sends a 4-beat packet while source 0 requests -> source 0 is held with s_tready[0]=0 until source 1's tlast is accepted, then source 0 is granted next.
REQ-035 m_tready toggles 1010... during a packet -> m_* stays stable while stalled, no beats are lost or duplicated, and the data sequence A,B,C,D is preserved.
REQ-036 aresetn asserted after beat 2 of a 5-beat packet -> m_tvalid=0 immediately; after release a new request from source 3 is granted cleanly.
